mem_rd_stream: RTL and testbench

Read-side initiator for the single-port weight/state memory (`mem_sp`). On a start request it reads `len` consecutive words beginning at `base` and presents them as a valid/ready stream to the LSTM datapath. It absorbs the memory's one-cycle read latency and tolerates arbitrary downstream backpressure without dropping or duplicating words. It sits between `mem_sp` and the MAC/activation units and owns the memory port for the duration of a transfer.

---
 rtl/mem_rd_stream_if.sv | 60 ++++++
 rtl/mem_rd_stream.sv | 184 ++++++++++++++++++
 tb/tb_mem_rd_stream.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rd_stream_if.sv
//==============================================================================
// Module      : mem_rd_stream_if
// Description : Bus bundle for mem_rd_stream: start/status handshake, the
//               single-port memory read port and the valid/ready output
//               stream.
//               Optional feature macro: MEM_RD_STRIDE_EN (adds 'stride').
// Ports       : req/base/len[/stride] -> start request (into the reader)
//               busy/done             -> transfer status (out of the reader)
//               mem_en/mem_addr       -> memory read command (out)
//               mem_rdata             -> memory read data, 1-cycle latency (in)
//               out_valid/out_data/out_last, out_ready -> output stream
// Modports    : master - the reader (mem_rd_stream)
//               slave  - the environment (controller, memory, consumer)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mem_rd_stream_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 10
);
    logic              req;
    logic [AWIDTH-1:0] base;
    logic [AWIDTH:0]   len;
`ifdef MEM_RD_STRIDE_EN
    logic [AWIDTH-1:0] stride;
`endif
    logic              busy;
    logic              done;
    logic              mem_en;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;
    logic              out_last;

`ifdef MEM_RD_STRIDE_EN
    modport master (
        input  req, base, len, stride, mem_rdata, out_ready,
        output busy, done, mem_en, mem_addr, out_valid, out_data, out_last
    );
    modport slave (
        output req, base, len, stride, mem_rdata, out_ready,
        input  busy, done, mem_en, mem_addr, out_valid, out_data, out_last
    );
`else
    modport master (
        input  req, base, len, mem_rdata, out_ready,
        output busy, done, mem_en, mem_addr, out_valid, out_data, out_last
    );
    modport slave (
        output req, base, len, mem_rdata, out_ready,
        input  busy, done, mem_en, mem_addr, out_valid, out_data, out_last
    );
`endif

endinterface : mem_rd_stream_if

`default_nettype wire

// File: rtl/mem_rd_stream.sv
//==============================================================================
// Module      : mem_rd_stream
// Description : Read-side initiator for the single-port weight/state memory.
//               On req (in IDLE) it reads 'len' words starting at 'base'
//               and streams them out over valid/ready, hiding the memory's
//               one-cycle read latency behind a 2-entry FIFO with credit-based
//               issue so backpressure never drops or duplicates a word.
//               Optional feature macro: MEM_RD_STRIDE_EN - when defined the
//               address increment is the 'stride' latched with req,
//               otherwise it is fixed at 1.
// Ports       : clk  - clock, all state on the rising edge
//               xrst - asynchronous active-low reset
//               bus  - mem_rd_stream_if.master (request, status, memory
//                      read port, output stream)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_rd_stream #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 10
) (
    input  wire logic            clk,
    input  wire logic            xrst,
    mem_rd_stream_if.master      bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [AWIDTH:0] c_CNT_ONE = (AWIDTH+1)'(1);

    state_t            state_q, state_d;
    logic              done_q,  done_d;

    logic [AWIDTH-1:0] addr_q;          // next address to issue
    logic [AWIDTH-1:0] last_addr_q;     // last issued address (held on mem_addr)
    logic [AWIDTH:0]   issue_cnt_q;     // reads still to issue
    logic              inflight_q;      // a read was issued last cycle
    logic              inflight_last_q; // ... and it was the final word
    logic [DWIDTH-1:0] buf_data_q [2];
    logic              buf_last_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;         // buffer occupancy 0..2
`ifdef MEM_RD_STRIDE_EN
    logic [AWIDTH-1:0] stride_q;
`endif

    logic              w_start;
    logic              w_hs;
    logic [1:0]        w_pending;
    logic              w_credit;
    logic              w_issue;
    logic              w_issue_last;
    logic [AWIDTH-1:0] w_incr;

`ifdef MEM_RD_STRIDE_EN
    assign w_incr = stride_q;
`else
    assign w_incr = AWIDTH'(1);
`endif

    assign w_start      = (state_q == S_IDLE) && bus.req && (bus.len != '0);
    assign w_hs         = bus.out_valid && bus.out_ready;
    // Words already owned by the buffer: stored plus the one in flight.
    assign w_pending    = count_q + {1'b0, inflight_q};
    // A slot freed by this cycle's handshake can be reused immediately, which
    // is what keeps the stream at full rate with only two entries.
    assign w_credit     = (w_pending < 2'd2) || ((w_pending == 2'd2) && w_hs);
    assign w_issue      = (state_q == S_RUN) && w_credit;
    assign w_issue_last = w_issue && (issue_cnt_q == c_CNT_ONE);

    assign bus.mem_en    = w_issue;
    assign bus.mem_addr  = w_issue ? addr_q : last_addr_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = buf_data_q[rd_ptr_q];
    assign bus.out_last  = bus.out_valid && buf_last_q[rd_ptr_q];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (bus.len != '0) begin
                        state_d = S_RUN;
                    end else begin
                        // Empty transfer: acknowledge without touching memory.
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_issue_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_hs && bus.out_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Address generation and read issue bookkeeping
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            addr_q          <= '0;
            last_addr_q     <= '0;
            issue_cnt_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
`ifdef MEM_RD_STRIDE_EN
            stride_q        <= '0;
`endif
        end else begin
            if (w_start) begin
                addr_q      <= bus.base;
                issue_cnt_q <= bus.len;
`ifdef MEM_RD_STRIDE_EN
                stride_q    <= bus.stride;
`endif
            end else if (w_issue) begin
                addr_q      <= addr_q + w_incr;   // wraps modulo 2^AWIDTH
                issue_cnt_q <= issue_cnt_q - c_CNT_ONE;
                last_addr_q <= addr_q;
            end
            inflight_q      <= w_issue;
            inflight_last_q <= w_issue_last;
        end
    end

    // Output FIFO: capture read data the cycle after issue, pop on handshake.
    // Credit control guarantees a free slot whenever a read lands.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q[0] <= 1'b0;
            buf_last_q[1] <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            if (inflight_q) begin
                buf_data_q[wr_ptr_q] <= bus.mem_rdata;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (w_hs) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({inflight_q, w_hs})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : mem_rd_stream

`default_nettype wire

// File: tb/tb_mem_rd_stream.sv
`timescale 1ns/1ps
`default_nettype none

module tb_mem_rd_stream;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic xrst;
    always #5 clk = ~clk;

    mem_rd_stream_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    mem_rd_stream #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    // Single-port memory model with one-cycle read latency, M[i] = i + 100.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // rmode: 0 ready always, 1 random 50%, 2 ready on odd cycles, 3 ready from cycle 8
    // inj:   cycle in which a stray req (base=500 len=5) is driven, 0 = none
    // exp_done: expected done cycle relative to req cycle 0, 0 = not checked
    typedef struct {
        string name;
        int    base;
        int    len;
        int    stride;
        int    rmode;
        int    inj;
        int    exp_first;
        int    exp_last;
        int    exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic run_xfer(input vec_t v);
        int cyc, nwords, naddr, ndone, done_cyc, max_out, nstab;
        int nbad_data, nbad_addr, issued, accepted, extra_en, ea;
        int first_d, last_d;
        bit fin, prev_stall, prev_last;
        logic [DW-1:0] prev_data;
        nwords = 0; naddr = 0; ndone = 0; done_cyc = -1; max_out = 0; nstab = 0;
        nbad_data = 0; nbad_addr = 0; issued = 0; accepted = 0; extra_en = 0;
        first_d = -1; last_d = -1; fin = 0; prev_stall = 0; prev_last = 0; prev_data = '0;

        @(posedge clk); #1;
        bus.req       = 1'b1;
        bus.base      = AW'(v.base);
        bus.len       = (AW+1)'(v.len);
`ifdef MEM_RD_STRIDE_EN
        bus.stride    = AW'(v.stride);
`endif
        bus.out_ready = (v.rmode == 0);
        @(negedge clk);
        if (bus.mem_en) extra_en++;   // nothing may issue in the req cycle

        cyc = 1;
        while (cyc < 300 && !fin) begin
            @(posedge clk); #1;
            bus.req = (v.inj != 0 && cyc == v.inj);
            if (bus.req) begin
                bus.base = AW'(500);
                bus.len  = (AW+1)'(5);
            end
            case (v.rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                2:       bus.out_ready = (cyc % 2) == 1;
                default: bus.out_ready = (cyc >= 8);
            endcase
            @(negedge clk);
            if (bus.mem_en) begin
                ea = (v.base + naddr * v.stride) % DEPTH;
                if (int'(bus.mem_addr) != ea) nbad_addr++;
                naddr++;
                issued++;
            end
            if (prev_stall) begin
                if (!bus.out_valid || bus.out_data != prev_data || bus.out_last != prev_last)
                    nstab++;
            end
            if (bus.out_valid && bus.out_ready) begin
                ea = (v.base + nwords * v.stride) % DEPTH;
                if (int'(bus.out_data) != ea + 100 || bus.out_last != (nwords == v.len - 1))
                    nbad_data++;
                if (nwords == 0) first_d = int'(bus.out_data);
                last_d = int'(bus.out_data);
                nwords++;
                accepted++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (bus.done) begin
                ndone++;
                done_cyc = cyc;
                fin = 1;
                chk({v.name, " busy low with done"}, bus.busy, 0);
            end
            cyc++;
        end
        if (!fin) chk({v.name, " done within cycle budget"}, 0, 1);

        // Quiet tail: no second done, no further memory traffic.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.req = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (bus.done) ndone++;
            if (bus.mem_en) extra_en++;
        end

        chk({v.name, " word count"},        nwords,    v.len);
        chk({v.name, " first word"},        first_d,   v.exp_first);
        chk({v.name, " last word"},         last_d,    v.exp_last);
        chk({v.name, " data/last errors"},  nbad_data, 0);
        chk({v.name, " reads issued"},      naddr,     v.len);
        chk({v.name, " address errors"},    nbad_addr, 0);
        chk({v.name, " stray mem_en"},      extra_en,  0);
        chk({v.name, " done pulses"},       ndone,     1);
        chk({v.name, " outstanding<=2"},    (max_out <= 2) ? 1 : 0, 1);
        chk({v.name, " stall stability"},   nstab,     0);
        if (v.exp_done != 0) chk({v.name, " done cycle"}, done_cyc, v.exp_done);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " busy"},      bus.busy,      0);
        chk({tag, " done"},      bus.done,      0);
        chk({tag, " mem_en"},    bus.mem_en,    0);
        chk({tag, " mem_addr"},  bus.mem_addr,  0);
        chk({tag, " out_valid"}, bus.out_valid, 0);
        chk({tag, " out_data"},  bus.out_data,  0);
        chk({tag, " out_last"},  bus.out_last,  0);
    endtask

    initial begin
        int ndone;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 100);

        //            name        base  len str mode inj first last done
        vecs.push_back('{"basic",    4,   8,  1, 0, 0,  104,  111, 11});
        vecs.push_back('{"wrap",  1022,   4,  1, 0, 0, 1122,  101,  7});
        vecs.push_back('{"single",1020,   1,  1, 0, 0, 1120, 1120,  4});
        vecs.push_back('{"stall",    8,   4,  1, 3, 0,  108,  111, 12});
        vecs.push_back('{"bp_rand",  0,  16,  1, 1, 0,  100,  115,  0});
        vecs.push_back('{"bp_alt", 500,   3,  1, 2, 0,  600,  602,  0});
        vecs.push_back('{"ign_req",  4,   8,  1, 0, 3,  104,  111, 11});
`ifdef MEM_RD_STRIDE_EN
        vecs.push_back('{"stride3", 10,   5,  3, 0, 0,  110,  122,  8});
        vecs.push_back('{"stride0", 10,   3,  0, 0, 0,  110,  110,  6});
`endif

        xrst          = 1'b0;
        bus.req       = 1'b0;
        bus.base      = '0;
        bus.len       = '0;
`ifdef MEM_RD_STRIDE_EN
        bus.stride    = '0;
`endif
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        xrst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_xfer(vecs[i]);

        // Empty transfer: done next cycle, no memory access, never busy.
        @(posedge clk); #1;
        bus.req = 1'b1; bus.base = AW'(7); bus.len = '0; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("len0 mem_en req cycle", bus.mem_en, 0);
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(negedge clk);
        chk("len0 done", bus.done, 1);
        chk("len0 busy", bus.busy, 0);
        chk("len0 mem_en", bus.mem_en, 0);
        @(negedge clk);
        chk("len0 done single", bus.done, 0);
        chk("len0 out_valid", bus.out_valid, 0);

        // Reset mid-transfer with the buffer full and stalled.
        @(posedge clk); #1;
        bus.req = 1'b1; bus.base = '0; bus.len = (AW+1)'(16); bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.req = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("midrst valid before", bus.out_valid, 1);
        chk("midrst busy before", bus.busy, 1);
        @(posedge clk); #1;
        xrst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midrst");
        @(posedge clk); #1;
        xrst = 1'b1;
        bus.out_ready = 1'b1;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done || bus.mem_en || bus.busy) ndone++;
        end
        chk("midrst quiet after", ndone, 0);
        run_xfer(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_mem_rd_stream

`default_nettype wire
